sdram_burst_scheduler: RTL and testbench
========================================

# sdram_burst_scheduler

Sequences the shared as4c4m16sa SDRAM controller between the camera write path and the display read path. It runs in the SDRAM clock domain and sits between the CDC staging FIFOs and the controller. It issues fixed-length write and read bursts into a single circular frame buffer, with read-starvation priority and bounded write fairness. It also walks and wraps the write and read frame addresses, with frame-sync realignment.

## Interface
Parameters:
- BURST_LENGTH, 8: words per burst; must match the controller's READ_BURST_LENGTH.
- VIDEO_END, 153600: frame size in 16-bit words; a multiple of BURST_LENGTH.
- LEVEL_WIDTH, 6: width of the FIFO level/free inputs.
- READ_URGENT_FREE, 24: read is urgent when rd_free >= this value.
- MAX_READ_STREAK, 4: maximum consecutive read bursts while a write is eligible.

Ports:
- clk  in  1  SDRAM clock; the only clock.
- reset  in  1  synchronous, active-high.
- wr_level  in  LEVEL_WIDTH  words available in the write staging FIFO (show-ahead).
- wr_data  in  16  write FIFO head word.
- wr_pop  out  1  pops one word from the write FIFO.
- wr_frame_sync  in  1  pulse; the next write burst starts at address 0.
- rd_free  in  LEVEL_WIDTH  free slots in the read staging FIFO.
- rd_push  out  1  pushes rd_data into the read FIFO.
- rd_data  out  16  read word.
- rd_frame_sync  in  1  pulse; the next read burst starts at address 0.
- command  out  2  to the controller: 0 idle, 1 write, 2 read.
- data_address  out  22  burst start word address, zero-extended.
- data_write  out  16  current write word.
- data_write_done  in  1  controller accepted data_write.
- data_read  in  16  controller read word.
- data_read_valid  in  1  data_read is valid.
- busy  out  1  high when the state is not IDLE.

## Operation
- States:
  - IDLE: command=0.
  - WRITE: command=1.
  - READ: command=2.
- Eligibility:
  - A write is eligible when wr_level >= BURST_LENGTH.
  - A read is eligible when rd_free >= BURST_LENGTH.
- Priority in IDLE:
  - An urgent, eligible read wins, unless streak == MAX_READ_STREAK and a write is eligible.
  - Otherwise an eligible write wins.
  - Otherwise an eligible read wins.
  - Otherwise the block stays in IDLE.
- Streak counter:
  - Increments on each granted read while a write is eligible.
  - Clears on a write grant, and when a read is granted with no write eligible.
- Write grant:
  - Sets data_write<=wr_data, pulses wr_pop, loads data_address<=wr_addr, clears beat=0.
  - On each data_write_done: beat++.
  - If beat != BURST_LENGTH-1: data_write<=wr_data and wr_pop pulses.
  - When beat == BURST_LENGTH-1: go to IDLE. Exactly BURST_LENGTH pops occur per burst.
- Read grant:
  - Loads data_address<=rd_addr, clears beat=0.
  - On each data_read_valid: rd_data<=data_read, rd_push pulses next cycle, beat++.
  - The last beat goes to IDLE.
- Address advance at the end of a burst:
  - addr <= (addr + BURST_LENGTH == VIDEO_END) ? 0 : addr + BURST_LENGTH.
  - Addresses are 18-bit unsigned, zero-extended to 22 bits.
- Frame sync:
  - A pulse sets a sticky pending flag.
  - If the flag is set at the end of a burst, or while that direction is in IDLE, the address becomes 0 instead of advancing, and the flag clears.
  - A sync never truncates a burst in flight.
- Reset values:
  - command=0, busy=0, wr_pop=0, rd_push=0, data_address=0, data_write=0, rd_data=0.
  - Addresses, beat, streak and pending flags all 0. State IDLE.
- Reset mid-burst:
  - Abandons the burst immediately.
  - The controller and the FIFOs are reset by the same reset.

## Timing
- Grant latency: command goes nonzero on the edge after IDLE sees eligibility, one cycle.
- After the last beat, command=0 for at least one cycle before the next grant.
- wr_pop is coincident with the registered data_write update. At most one pop per cycle.
- rd_push/rd_data lag data_read_valid by exactly one cycle.
- data_address is stable for the whole burst.
- A sync pulse and a burst end in the same cycle: the address goes to 0.
- data_write_done or data_read_valid arriving in IDLE, or in the wrong state, is ignored.

## Configuration
- SDRAM_SCHED_STATS_EN defined:
  - Adds outputs write_burst_count[15:0], read_burst_count[15:0] and urgent_read_count[15:0].
  - Each increments at its burst completion (urgent counts granted urgent reads).
  - All reset to 0 and wrap at 16 bits.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- Package sdram_sched_pkg:
  - typedef enum logic [1:0] sdram_cmd_t: CMD_IDLE=0, CMD_WRITE=1, CMD_READ=2.
  - Scheduler state enum.
  - ADDR_WIDTH=18.
- Sub-module burst_address_walker, instantiated twice (write and read):
  - Holds the address, the sync pending flag, the advance and the wrap.
  - Inputs: advance, sync.
  - Output: addr.

## Test plan
- wr_level=8, rd_free=0 -> one write burst at address 0; 8 wr_pop; command returns to 0; wr_addr=8.
- rd_free=32 (urgent) and wr_level=8 together -> read granted first; after 4 reads with a write still eligible, a write is forced.
- Write address at VIDEO_END-8, one burst -> address wraps to 0; the next burst's data_address=0.
- rd_frame_sync pulsed during read beat 3 -> burst completes with 8 pushes; the next read data_address=0.
- data_read_valid 8 beats with values 0x1000..0x1007 -> rd_push with the same values, each one cycle later.
- reset asserted on write beat 4 -> next cycle command=0, busy=0; no further wr_pop; addresses 0.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM burst scheduler: controller command codes, scheduler states, address width.
// Latency: none (types and constants only).
// Backpressure: none.
package sdram_sched_pkg;

    localparam int ADDR_WIDTH = 18;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } sdram_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/burst_address_walker.sv
// Frame address walker for one direction: advances by one burst per completion, wraps at frame end, realigns on sync.
// Latency: addr_o reflects a pending/arriving sync combinationally while idle; advances register at burst end.
// Backpressure: none; a sync arriving mid-burst waits in a sticky flag until the burst completes.
module burst_address_walker
    import sdram_sched_pkg::*;
#(
    parameter int BURST_LENGTH = 8,
    parameter int VIDEO_END    = 153600
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active_i,
    input  logic                  advance_i,
    input  logic                  sync_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
    logic                  pending_q, pending_d, sync_now;

    // Next address: a seen sync forces 0 at burst end or whenever this direction is not bursting
    always_comb begin
        sync_now  = pending_q | sync_i;
        addr_inc  = addr_q + ADDR_WIDTH'(BURST_LENGTH);
        addr_d    = addr_q;
        pending_d = sync_now;
        if (advance_i) begin
            addr_d    = (sync_now || (addr_inc == ADDR_WIDTH'(VIDEO_END))) ? '0 : addr_inc;
            pending_d = 1'b0;
        end else if (!active_i && sync_now) begin
            addr_d    = '0;
            pending_d = 1'b0;
        end
    end

    // A grant in the same cycle as a sync already sees address 0
    assign addr_o = (!active_i && sync_now) ? '0 : addr_q;

    // Address and sticky sync flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/sdram_burst_scheduler.sv
// Arbitrates fixed-length SDRAM write/read bursts into a circular frame buffer (read-urgent priority, bounded read streak).
// Latency: command one cycle after eligibility in IDLE; rd_push/rd_data one cycle after data_read_valid; wr_pop same-cycle with data_write load.
// Backpressure: beats advance only on data_write_done / data_read_valid; optional counters under SDRAM_SCHED_STATS_EN.
module sdram_burst_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int BURST_LENGTH     = 8,
    parameter int VIDEO_END        = 153600,
    parameter int LEVEL_WIDTH      = 6,
    parameter int READ_URGENT_FREE = 24,
    parameter int MAX_READ_STREAK  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEVEL_WIDTH-1:0] wr_level,
    input  logic [15:0]            wr_data,
    output logic                   wr_pop,
    input  logic                   wr_frame_sync,
    input  logic [LEVEL_WIDTH-1:0] rd_free,
    output logic                   rd_push,
    output logic [15:0]            rd_data,
    input  logic                   rd_frame_sync,
    output logic [1:0]             command,
    output logic [21:0]            data_address,
    output logic [15:0]            data_write,
    input  logic                   data_write_done,
    input  logic [15:0]            data_read,
    input  logic                   data_read_valid,
    output logic                   busy
`ifdef SDRAM_SCHED_STATS_EN
    ,
    output logic [15:0]            write_burst_count,
    output logic [15:0]            read_burst_count,
    output logic [15:0]            urgent_read_count
`endif
);

    localparam int BEAT_W   = $clog2(BURST_LENGTH);
    localparam int STREAK_W = $clog2(MAX_READ_STREAK + 1);

    sched_state_t          state_q;
    sdram_cmd_t            command_q;
    logic [21:0]           data_address_q;
    logic [15:0]           data_write_q, rd_data_q;
    logic                  rd_push_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [STREAK_W-1:0]   streak_q;

    logic                  wr_elig, rd_elig, rd_urgent, streak_at_max;
    logic                  grant_wr, grant_rd, beat_last;
    logic                  wr_beat, rd_beat, wr_end, rd_end;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    assign wr_elig       = wr_level >= LEVEL_WIDTH'(BURST_LENGTH);
    assign rd_elig       = rd_free  >= LEVEL_WIDTH'(BURST_LENGTH);
    assign rd_urgent     = rd_free  >= LEVEL_WIDTH'(READ_URGENT_FREE);
    assign streak_at_max = streak_q == STREAK_W'(MAX_READ_STREAK);
    assign beat_last     = beat_q == BEAT_W'(BURST_LENGTH - 1);
    assign wr_beat       = (state_q == ST_WRITE) && data_write_done;
    assign rd_beat       = (state_q == ST_READ)  && data_read_valid;
    assign wr_end        = wr_beat && beat_last;
    assign rd_end        = rd_beat && beat_last;

    // IDLE arbitration: urgent read unless the streak cap hands the slot to a waiting write
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state_q == ST_IDLE) begin
            if (rd_elig && rd_urgent && !(streak_at_max && wr_elig)) begin
                grant_rd = 1'b1;
            end else if (wr_elig) begin
                grant_wr = 1'b1;
            end else if (rd_elig) begin
                grant_rd = 1'b1;
            end
        end
    end

    // Pop lands on the same edge that copies the FIFO head into data_write
    assign wr_pop = !reset && (grant_wr || (wr_beat && !beat_last));

    burst_address_walker #(
        .BURST_LENGTH (BURST_LENGTH),
        .VIDEO_END    (VIDEO_END)
    ) u_wr_addr (
        .clk       (clk),
        .reset     (reset),
        .active_i  (state_q == ST_WRITE),
        .advance_i (wr_end),
        .sync_i    (wr_frame_sync),
        .addr_o    (wr_addr)
    );

    burst_address_walker #(
        .BURST_LENGTH (BURST_LENGTH),
        .VIDEO_END    (VIDEO_END)
    ) u_rd_addr (
        .clk       (clk),
        .reset     (reset),
        .active_i  (state_q == ST_READ),
        .advance_i (rd_end),
        .sync_i    (rd_frame_sync),
        .addr_o    (rd_addr)
    );

    // Burst FSM with registered controller-facing outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            command_q      <= CMD_IDLE;
            data_address_q <= '0;
            data_write_q   <= '0;
            rd_data_q      <= '0;
            rd_push_q      <= 1'b0;
            beat_q         <= '0;
            streak_q       <= '0;
        end else begin
            rd_push_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_wr) begin
                        state_q        <= ST_WRITE;
                        command_q      <= CMD_WRITE;
                        data_write_q   <= wr_data;
                        data_address_q <= {{(22-ADDR_WIDTH){1'b0}}, wr_addr};
                        beat_q         <= '0;
                        streak_q       <= '0;
                    end else if (grant_rd) begin
                        state_q        <= ST_READ;
                        command_q      <= CMD_READ;
                        data_address_q <= {{(22-ADDR_WIDTH){1'b0}}, rd_addr};
                        beat_q         <= '0;
                        streak_q       <= wr_elig ? streak_q + STREAK_W'(1) : '0;
                    end
                end
                ST_WRITE: begin
                    if (data_write_done) begin
                        if (beat_last) begin
                            state_q   <= ST_IDLE;
                            command_q <= CMD_IDLE;
                        end else begin
                            beat_q       <= beat_q + BEAT_W'(1);
                            data_write_q <= wr_data;
                        end
                    end
                end
                ST_READ: begin
                    if (data_read_valid) begin
                        rd_data_q <= data_read;
                        rd_push_q <= 1'b1;
                        beat_q    <= beat_q + BEAT_W'(1);
                        if (beat_last) begin
                            state_q   <= ST_IDLE;
                            command_q <= CMD_IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    command_q <= CMD_IDLE;
                end
            endcase
        end
    end

    assign command      = command_q;
    assign busy         = (state_q != ST_IDLE);
    assign data_address = data_address_q;
    assign data_write   = data_write_q;
    assign rd_data      = rd_data_q;
    assign rd_push      = rd_push_q;

`ifdef SDRAM_SCHED_STATS_EN
    logic        urgent_q;
    logic [15:0] wr_cnt_q, rd_cnt_q, urg_cnt_q;

    // Completed-burst counters; read urgency is captured at grant and counted at completion
    always_ff @(posedge clk) begin
        if (reset) begin
            urgent_q  <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            urg_cnt_q <= '0;
        end else begin
            if (grant_rd) urgent_q <= rd_urgent;
            if (wr_end)   wr_cnt_q <= wr_cnt_q + 16'd1;
            if (rd_end) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
                if (urgent_q) urg_cnt_q <= urg_cnt_q + 16'd1;
            end
        end
    end

    assign write_burst_count = wr_cnt_q;
    assign read_burst_count  = rd_cnt_q;
    assign urgent_read_count = urg_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Self-checking bench for sdram_burst_scheduler: random FIFO levels, syncs and controller handshakes.
// Latency: a reference model predicts grants, addresses, write words and read pushes per cycle.
// Backpressure: the controller stub inserts random gaps between beats and stray handshakes.
module tb_sdram_burst_scheduler;

    localparam int BL   = 8;
    localparam int VE   = 80;
    localparam int LW   = 6;
    localparam int URG  = 24;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [LW-1:0] wr_level = '0, rd_free = '0;
    logic [15:0]   wr_data = '0, data_read = '0;
    logic          wr_frame_sync = 1'b0, rd_frame_sync = 1'b0;
    logic          data_write_done = 1'b0, data_read_valid = 1'b0;
    logic          wr_pop, rd_push, busy;
    logic [15:0]   rd_data, data_write;
    logic [1:0]    command;
    logic [21:0]   data_address;
`ifdef SDRAM_SCHED_STATS_EN
    logic [15:0]   wbc, rbc, ubc;
`endif

    always #5 clk = ~clk;

    sdram_burst_scheduler #(
        .BURST_LENGTH(BL), .VIDEO_END(VE), .LEVEL_WIDTH(LW),
        .READ_URGENT_FREE(URG), .MAX_READ_STREAK(MAXS)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_level(wr_level), .wr_data(wr_data), .wr_pop(wr_pop), .wr_frame_sync(wr_frame_sync),
        .rd_free(rd_free), .rd_push(rd_push), .rd_data(rd_data), .rd_frame_sync(rd_frame_sync),
        .command(command), .data_address(data_address), .data_write(data_write),
        .data_write_done(data_write_done), .data_read(data_read), .data_read_valid(data_read_valid),
        .busy(busy)
`ifdef SDRAM_SCHED_STATS_EN
        , .write_burst_count(wbc), .read_burst_count(rbc), .urgent_read_count(ubc)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Write staging FIFO contents: word i of an endless stream
    function automatic logic [15:0] src_word(input int i);
        return 16'((i * 40503) ^ 32'h5a3c);
    endfunction

    // ---------------- reference model state ----------------
    typedef struct packed { logic [15:0] d; logic [31:0] due; } rexp_t;
    rexp_t rq[$];
    int    addr_q[$];
    int    pop_idx = 0, acc_idx = 0;
    int    m_waddr = 0, m_raddr = 0, m_streak = 0;
    bit    m_wpend = 0, m_rpend = 0;
    int    m_wbeats = 0, m_rbeats = 0, m_popcnt = 0, burst_addr = 0;
    int    wr_bursts = 0, rd_bursts = 0;
    logic [1:0] exp_cmd = 2'd0;
    bit    exp_vld = 0, reset_prev = 0;
    logic [1:0] prev_cmd = 2'd0;
    bit    dir_rd = 0;

    // Monitor / scoreboard: sample away from the active edge
    always @(negedge clk) begin : monitor
        bit we, re, ur;
        int dec, a;
        rexp_t r;
        cyc++;
        if (exp_vld) begin
            chk("command", command, exp_cmd);
            chk("busy", busy, exp_cmd != 2'd0);
        end
        if (rd_push) begin
            if (rq.size() == 0) begin
                chk("rd_push_unexpected", 1, 0);
            end else begin
                r = rq.pop_front();
                chk("rd_data", rd_data, r.d);
                chk("rd_push_lag", cyc, r.due);
            end
        end
        while (rq.size() > 0 && rq[0].due < cyc) begin
            r = rq.pop_front();
            chk("rd_push_missing", 0, 1);
        end

        if (reset) begin
            chk("rst_wr_pop", wr_pop, 0);
            if (reset_prev) begin
                chk("rst_rd_push", rd_push, 0);
                chk("rst_data_address", data_address, 0);
                chk("rst_data_write", data_write, 0);
                chk("rst_rd_data", rd_data, 0);
            end
            m_waddr = 0; m_raddr = 0; m_streak = 0; m_wpend = 0; m_rpend = 0;
            m_wbeats = 0; m_rbeats = 0; m_popcnt = 0;
            pop_idx = 0; acc_idx = 0;
            rq.delete(); addr_q.delete();
            exp_cmd = 2'd0; exp_vld = 1;
        end else begin
            if (wr_frame_sync) m_wpend = 1;
            if (rd_frame_sync) m_rpend = 1;
            if (wr_pop) pop_idx++;
            case (command)
                2'd0: begin
                    we = wr_level >= BL; re = rd_free >= BL; ur = rd_free >= URG;
                    dec = 0;
                    if (re && ur && !(m_streak == MAXS && we)) dec = 2;
                    else if (we) dec = 1;
                    else if (re) dec = 2;
                    chk("idle_wr_pop", wr_pop, dec == 1);
                    if (dec == 1) begin
                        if (m_wpend) begin m_waddr = 0; m_wpend = 0; end
                        addr_q.push_back(m_waddr);
                        m_streak = 0; m_wbeats = 0; m_popcnt = wr_pop ? 1 : 0;
                    end else if (dec == 2) begin
                        if (m_rpend) begin m_raddr = 0; m_rpend = 0; end
                        addr_q.push_back(m_raddr);
                        m_streak = we ? m_streak + 1 : 0; m_rbeats = 0;
                    end
                    exp_cmd = 2'(dec);
                end
                2'd1: begin
                    exp_cmd = 2'd1;
                    if (prev_cmd == 2'd0) begin
                        a = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
                        chk("wr_burst_address", data_address, a);
                        burst_addr = a;
                    end
                    if (wr_pop) m_popcnt++;
                    if (data_write_done) begin
                        chk("data_write", data_write, src_word(acc_idx));
                        acc_idx++; m_wbeats++;
                        if (m_wbeats == BL) begin
                            chk("pops_per_burst", m_popcnt, BL);
                            chk("wr_address_hold", data_address, burst_addr);
                            m_waddr = (m_waddr + BL == VE) ? 0 : m_waddr + BL;
                            exp_cmd = 2'd0; wr_bursts++;
                        end
                    end
                end
                2'd2: begin
                    exp_cmd = 2'd2;
                    if (prev_cmd == 2'd0) begin
                        a = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
                        chk("rd_burst_address", data_address, a);
                        burst_addr = a;
                    end
                    if (data_read_valid) begin
                        rq.push_back('{d: data_read, due: 32'(cyc + 1)});
                        m_rbeats++;
                        if (m_rbeats == BL) begin
                            chk("rd_address_hold", data_address, burst_addr);
                            m_raddr = (m_raddr + BL == VE) ? 0 : m_raddr + BL;
                            exp_cmd = 2'd0; rd_bursts++;
                        end
                    end
                end
                default: chk("command_legal", command, 0);
            endcase
        end
        reset_prev = reset;
        prev_cmd   = command;
    end

    // Controller stub and write FIFO head; drives just after the active edge
    always @(posedge clk) begin : stub
        static int sbeats = 0;
        #1;
        wr_data = src_word(pop_idx);
        data_write_done = 1'b0;
        data_read_valid = 1'b0;
        if (reset || command == 2'd0) begin
            sbeats = 0;
            data_write_done = ($urandom_range(0, 7) == 0);
            data_read_valid = ($urandom_range(0, 7) == 0);
            data_read = 16'($urandom);
        end else if (command == 2'd1) begin
            data_read_valid = ($urandom_range(0, 15) == 0);
            data_read = 16'($urandom);
            if (sbeats < BL && $urandom_range(0, 1) == 1) begin
                data_write_done = 1'b1;
                sbeats++;
            end
        end else begin
            data_write_done = ($urandom_range(0, 15) == 0);
            if (sbeats < BL && $urandom_range(0, 1) == 1) begin
                data_read = dir_rd ? 16'h1000 + 16'(sbeats) : 16'($urandom);
                data_read_valid = 1'b1;
                sbeats++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bursts(input bit is_wr, input int target, input int budget, input string name);
        int n = 0;
        while ((is_wr ? wr_bursts : rd_bursts) < target && n < budget) begin
            step();
            n++;
        end
        chk(name, (is_wr ? wr_bursts : rd_bursts) >= target, 1);
    endtask

    initial begin : driver
        int n;
        repeat (4) step();
        reset = 1'b0;
        repeat (3) step();

        // Single write burst from address 0
        wr_level = 6'd8; rd_free = 6'd0;
        wait_bursts(1, 1, 200, "first_write_timeout");
        wr_level = 6'd0;
        step();
        chk("wr_addr_after_first", 32'(dut.u_wr_addr.addr_o), 8);

        // Urgent reads against an eligible write: four reads, then a forced write
        wr_level = 6'd8; rd_free = 6'd32;
        wait_bursts(1, 2, 800, "streak_write_timeout");
        chk("reads_before_forced_write", rd_bursts, MAXS);
        wr_level = 6'd0; rd_free = 6'd0;
        repeat (3) step();

        // Back-to-back writes across the frame wrap
        wr_level = 6'd12;
        wait_bursts(1, wr_bursts + 12, 12 * 60, "wrap_write_timeout");
        wr_level = 6'd0;
        repeat (3) step();

        // Read frame sync during a burst; directed read values
        dir_rd = 1; rd_free = 6'd8;
        n = 0;
        while (!(command == 2'd2 && m_rbeats == 3) && n < 300) begin step(); n++; end
        chk("rd_beat3_reached", m_rbeats, 3);
        rd_frame_sync = 1'b1; step(); rd_frame_sync = 1'b0;
        wait_bursts(0, rd_bursts + 2, 200, "rd_sync_timeout");
        rd_free = 6'd0; dir_rd = 0;
        repeat (3) step();

        // Random traffic with occasional frame syncs
        for (int i = 0; i < 3000; i++) begin
            wr_level      = LW'($urandom_range(0, 20));
            rd_free       = LW'($urandom_range(0, 32));
            wr_frame_sync = ($urandom_range(0, 99) == 0);
            rd_frame_sync = ($urandom_range(0, 99) == 0);
            step();
        end
        wr_frame_sync = 1'b0; rd_frame_sync = 1'b0;
        wr_level = 6'd0; rd_free = 6'd0;
        repeat (20) step();

        // Reset in the middle of a write burst
        wr_level = 6'd8;
        n = 0;
        while (!(command == 2'd1 && m_wbeats == 4) && n < 300) begin step(); n++; end
        chk("wr_beat4_reached", m_wbeats, 4);
        reset = 1'b1; wr_level = 6'd0;
        repeat (2) step();
        chk("rst_wr_addr", 32'(dut.u_wr_addr.addr_o), 0);
        chk("rst_rd_addr", 32'(dut.u_rd_addr.addr_o), 0);
        reset = 1'b0;
        repeat (3) step();
        wr_level = 6'd8;
        wait_bursts(1, wr_bursts + 1, 200, "post_reset_write_timeout");
        wr_level = 6'd0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
